// File: rtl/fadd_stream_driver_if.sv
// fadd_stream_driver_if
//   Bundles the three handshake channels around the adder driver:
//     cmd_*  : host offers an operand pair (host -> driver)
//     fadd_* : operand A/B out to the adder, result Z back from it, adder reset
//     res_*  : result, latency and timeout flag returned to the host
//   All channels follow the stb/ack rule: a transfer happens on a rising
//   edge where both stb and ack are 1.
//   master : the driver side (fadd_stream_driver)
//   slave  : the environment side (host plus adder)
interface fadd_stream_driver_if;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_stb;
    logic        cmd_ack;

    logic [31:0] fadd_a;
    logic        fadd_a_stb;
    logic        fadd_a_ack;
    logic [31:0] fadd_b;
    logic        fadd_b_stb;
    logic        fadd_b_ack;
    logic [31:0] fadd_z;
    logic        fadd_z_stb;
    logic        fadd_z_ack;
    logic        fadd_rst;

    logic [31:0] res_z;
    logic [15:0] res_cycles;
    logic        res_err;
    logic        res_stb;
    logic        res_ack;

    modport master (
        input  cmd_a, cmd_b, cmd_stb,
        output cmd_ack,
        output fadd_a, fadd_a_stb,
        input  fadd_a_ack,
        output fadd_b, fadd_b_stb,
        input  fadd_b_ack,
        input  fadd_z, fadd_z_stb,
        output fadd_z_ack, fadd_rst,
        output res_z, res_cycles, res_err, res_stb,
        input  res_ack
    );

    modport slave (
        output cmd_a, cmd_b, cmd_stb,
        input  cmd_ack,
        input  fadd_a, fadd_a_stb,
        output fadd_a_ack,
        input  fadd_b, fadd_b_stb,
        output fadd_b_ack,
        output fadd_z, fadd_z_stb,
        input  fadd_z_ack, fadd_rst,
        input  res_z, res_cycles, res_err, res_stb,
        output res_ack
    );
endinterface

// File: rtl/fadd_stream_driver.sv
// fadd_stream_driver
//   Initiator for a float adder's stb/ack operand/result protocol. Takes an
//   operand pair from the host, hands A then B to the adder, collects Z and
//   returns it with the number of cycles from command capture to Z capture.
//   If Z does not arrive within TIMEOUT cycles the operation is aborted: the
//   adder gets a one-cycle fadd_rst pulse and the host receives a quiet NaN
//   with res_err set.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - master side of fadd_stream_driver_if (cmd_*, fadd_*, res_*)
// States:
//   IDLE    | ready for a command (cmd_ack raised)
//   SEND_A  | offering operand A to the adder
//   SEND_B  | offering operand B to the adder
//   WAIT_Z  | accepting the adder result
//   PUT_RES | offering the result to the host
module fadd_stream_driver #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic                 clk,
    input  logic                 rst,
    fadd_stream_driver_if.master bus
);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_Z, PUT_RES} state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_sat;
    logic        timeout_hit;
    logic        z_xfer;

    assign cnt_sat     = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    // cnt+1 == TIMEOUT written without the wrapping increment.
    assign timeout_hit = (cnt == TIMEOUT - 16'd1);
    assign z_xfer      = bus.fadd_z_ack && bus.fadd_z_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.cmd_ack    <= 1'b0;
            bus.fadd_a_stb <= 1'b0;
            bus.fadd_b_stb <= 1'b0;
            bus.fadd_z_ack <= 1'b0;
            bus.fadd_rst   <= 1'b0;
            bus.res_z      <= '0;
            bus.res_cycles <= '0;
            bus.res_err    <= 1'b0;
            bus.res_stb    <= 1'b0;
        end else begin
            bus.fadd_rst <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ack <= 1'b1;
                    if (bus.cmd_stb && bus.cmd_ack) begin
                        bus.fadd_a     <= bus.cmd_a;
                        bus.fadd_b     <= bus.cmd_b;
                        bus.cmd_ack    <= 1'b0;
                        bus.fadd_a_stb <= 1'b1;
                        cnt            <= '0;
                        state          <= SEND_A;
                    end
                end
                SEND_A, SEND_B, WAIT_Z: begin
                    cnt <= cnt_sat;
                    // A Z transfer on the timeout edge still counts as a normal result.
                    if (state == WAIT_Z && z_xfer) begin
                        bus.res_z      <= bus.fadd_z;
                        bus.res_cycles <= cnt_sat;
                        bus.res_err    <= 1'b0;
                        bus.fadd_z_ack <= 1'b0;
                        bus.res_stb    <= 1'b1;
                        state          <= PUT_RES;
                    end else if (timeout_hit) begin
                        bus.fadd_a_stb <= 1'b0;
                        bus.fadd_b_stb <= 1'b0;
                        bus.fadd_z_ack <= 1'b0;
                        bus.fadd_rst   <= 1'b1;
                        bus.res_z      <= QNAN;
                        bus.res_err    <= 1'b1;
                        bus.res_cycles <= TIMEOUT;
                        bus.res_stb    <= 1'b1;
                        state          <= PUT_RES;
                    end else if (state == SEND_A) begin
                        if (bus.fadd_a_stb && bus.fadd_a_ack) begin
                            bus.fadd_a_stb <= 1'b0;
                            bus.fadd_b_stb <= 1'b1;
                            state          <= SEND_B;
                        end
                    end else if (state == SEND_B) begin
                        if (bus.fadd_b_stb && bus.fadd_b_ack) begin
                            bus.fadd_b_stb <= 1'b0;
                            bus.fadd_z_ack <= 1'b1;
                            state          <= WAIT_Z;
                        end
                    end
                end
                PUT_RES: begin
                    if (bus.res_stb && bus.res_ack) begin
                        bus.res_stb <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_stream_driver.sv
// tb_fadd_stream_driver
//   Drives fadd_stream_driver with a host/adder responder whose ack and stb
//   delays are programmable; the responder's adder returns Z = A ^ B.
//   Expected results come from a per-command model: an op with responder
//   delays da/db/dz completes in 3+da+db+dz cycles, or times out at TIMEOUT.
module tb_fadd_stream_driver;

    localparam logic [15:0] TO = 16'd16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fadd_stream_driver_if bus();

    fadd_stream_driver #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        err;
        logic [15:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int da = 0, db = 0, dz = 0, res_dly = 2;
    bit z_never = 1'b0;

    int          n_res = 0;
    int          n_rst_pulse = 0;
    logic [31:0] last_z = '0;
    logic [15:0] last_cyc = '0;
    logic        last_err = 1'b0;
    logic [31:0] rcv_a = '0, rcv_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host result acceptor and adder responder.
    initial begin : env
        bit pa, pb, pz, pr, prst;
        int ca, cb, cz, cr;
        ca = 0; cb = 0; cz = 0; cr = 0;
        bus.fadd_a_ack = 1'b0;
        bus.fadd_b_ack = 1'b0;
        bus.fadd_z_stb = 1'b0;
        bus.fadd_z     = '0;
        bus.res_ack    = 1'b0;
        forever begin
            @(negedge clk);
            pa   = bus.fadd_a_stb && bus.fadd_a_ack;
            pb   = bus.fadd_b_stb && bus.fadd_b_ack;
            pz   = bus.fadd_z_stb && bus.fadd_z_ack;
            pr   = bus.res_stb && bus.res_ack;
            prst = rst;
            if (pa) rcv_a = bus.fadd_a;
            if (pb) rcv_b = bus.fadd_b;
            @(posedge clk);
            #1;
            if (prst) begin
                bus.fadd_a_ack = 1'b0;
                bus.fadd_b_ack = 1'b0;
                bus.fadd_z_stb = 1'b0;
                bus.res_ack    = 1'b0;
                ca = 0; cb = 0; cz = 0; cr = 0;
            end else begin
                if (pa || !bus.fadd_a_stb) begin
                    bus.fadd_a_ack = 1'b0;
                    ca = 0;
                end else if (!bus.fadd_a_ack) begin
                    if (ca >= da) bus.fadd_a_ack = 1'b1;
                    else ca++;
                end

                if (pb || !bus.fadd_b_stb) begin
                    bus.fadd_b_ack = 1'b0;
                    cb = 0;
                end else if (!bus.fadd_b_ack) begin
                    if (cb >= db) bus.fadd_b_ack = 1'b1;
                    else cb++;
                end

                if (pz || !bus.fadd_z_ack) begin
                    bus.fadd_z_stb = 1'b0;
                    cz = 0;
                end else if (!bus.fadd_z_stb && !z_never) begin
                    if (cz >= dz) begin
                        bus.fadd_z_stb = 1'b1;
                        bus.fadd_z     = rcv_a ^ rcv_b;
                    end else cz++;
                end

                if (pr) begin
                    bus.res_ack = 1'b0;
                    cr = 0;
                end else if (bus.res_stb && !bus.res_ack) begin
                    if (cr >= res_dly) bus.res_ack = 1'b1;
                    else cr++;
                end
            end
        end
    end

    // Compare process: checks the DUT against the model every cycle.
    initial begin : mon
        int   k;
        int   total;
        bit   busy, cur_to, to;
        exp_t e;
        logic p_as, p_aa, p_bs, p_ba, p_rs, p_ra, p_rst, p_re;
        logic [31:0] p_a, p_b, p_rz;
        logic [15:0] p_rc;
        k = 0; busy = 0; cur_to = 0;
        p_as = 0; p_aa = 0; p_bs = 0; p_ba = 0; p_rs = 0; p_ra = 0; p_rst = 1; p_re = 0;
        p_a = '0; p_b = '0; p_rz = '0; p_rc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                busy = 0;
            end else begin
                if (busy) k++;
                check("fadd_rst", 32'(bus.fadd_rst), 32'(busy && cur_to && k == int'(TO)));
                if (bus.fadd_rst) n_rst_pulse++;
                check("cmd_ack_during_res_stb", 32'(bus.cmd_ack && bus.res_stb), 32'd0);
                if (bus.res_stb) check("fadd_z_ack_in_result", 32'(bus.fadd_z_ack), 32'd0);
                if (!p_rst && p_as && !p_aa && bus.fadd_a_stb) check("fadd_a_stable", bus.fadd_a, p_a);
                if (!p_rst && p_bs && !p_ba && bus.fadd_b_stb) check("fadd_b_stable", bus.fadd_b, p_b);
                if (!p_rst && p_rs && !p_ra) begin
                    check("res_stb_held", 32'(bus.res_stb), 32'd1);
                    check("res_z_stable", bus.res_z, p_rz);
                    check("res_cycles_stable", 32'(bus.res_cycles), 32'(p_rc));
                    check("res_err_stable", 32'(bus.res_err), 32'(p_re));
                end
                if (bus.fadd_a_stb && bus.fadd_a_ack && exp_q.size() > 0)
                    check("fadd_a_value", bus.fadd_a, exp_q[0].a);
                if (bus.fadd_b_stb && bus.fadd_b_ack && exp_q.size() > 0)
                    check("fadd_b_value", bus.fadd_b, exp_q[0].b);
                if (bus.res_stb && bus.res_ack) begin
                    if (exp_q.size() == 0) begin
                        check("res_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_z", bus.res_z, e.z);
                        check("res_err", 32'(bus.res_err), 32'(e.err));
                        check("res_cycles", 32'(bus.res_cycles), 32'(e.cyc));
                    end
                    last_z   = bus.res_z;
                    last_cyc = bus.res_cycles;
                    last_err = bus.res_err;
                    n_res++;
                    busy = 0;
                end
                if (bus.cmd_stb && bus.cmd_ack) begin
                    total = 3 + da + db + dz;
                    to    = z_never || (total > int'(TO));
                    e.a   = bus.cmd_a;
                    e.b   = bus.cmd_b;
                    e.z   = to ? 32'h7FC00000 : (bus.cmd_a ^ bus.cmd_b);
                    e.err = to;
                    e.cyc = to ? TO : 16'(total);
                    exp_q.push_back(e);
                    busy   = 1;
                    cur_to = to;
                    k      = -1;
                end
            end
            p_as = bus.fadd_a_stb; p_aa = bus.fadd_a_ack; p_a = bus.fadd_a;
            p_bs = bus.fadd_b_stb; p_ba = bus.fadd_b_ack; p_b = bus.fadd_b;
            p_rs = bus.res_stb;    p_ra = bus.res_ack;
            p_rz = bus.res_z;      p_rc = bus.res_cycles;  p_re = bus.res_err;
            p_rst = rst;
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] b);
        int t;
        bit done;
        t = 0; done = 0;
        bus.cmd_a   = a;
        bus.cmd_b   = b;
        bus.cmd_stb = 1'b1;
        while (!done && t < 200) begin
            @(negedge clk);
            done = bus.cmd_ack;
            @(posedge clk);
            #1;
            t++;
        end
        bus.cmd_stb = 1'b0;
        check("cmd_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_res(input int n);
        int t;
        t = 0;
        while (n_res < n && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("result_arrived", 32'(n_res >= n), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ack"},    32'(bus.cmd_ack),    32'd0);
        check({tag, "_a_stb"},      32'(bus.fadd_a_stb), 32'd0);
        check({tag, "_b_stb"},      32'(bus.fadd_b_stb), 32'd0);
        check({tag, "_z_ack"},      32'(bus.fadd_z_ack), 32'd0);
        check({tag, "_fadd_rst"},   32'(bus.fadd_rst),   32'd0);
        check({tag, "_res_stb"},    32'(bus.res_stb),    32'd0);
        check({tag, "_res_err"},    32'(bus.res_err),    32'd0);
        check({tag, "_res_z"},      bus.res_z,           32'd0);
        check({tag, "_res_cycles"}, 32'(bus.res_cycles), 32'd0);
    endtask

    logic [31:0] b2b_a [4];
    logic [31:0] b2b_b [4];

    initial begin : main
        int n0, p0, t;
        logic [15:0] base_cyc;
        b2b_a[0] = 32'h3F800000; b2b_b[0] = 32'h3F800000;
        b2b_a[1] = 32'h40400000; b2b_b[1] = 32'h40800000;
        b2b_a[2] = 32'hBF800000; b2b_b[2] = 32'h3F800000;
        b2b_a[3] = 32'h12345678; b2b_b[3] = 32'h0F0F0F0F;

        rst = 1'b1;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_stb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ack_after_reset", 32'(bus.cmd_ack), 32'd1);

        // Zero-delay responder.
        da = 0; db = 0; dz = 0; res_dly = 2;
        n0 = n_res;
        send_cmd(32'h3F800000, 32'h40000000);
        wait_res(n0 + 1);
        check("zd_adder_a", rcv_a, 32'h3F800000);
        check("zd_adder_b", rcv_b, 32'h40000000);
        check("zd_res_z", last_z, 32'h7F800000);
        check("zd_res_err", 32'(last_err), 32'd0);
        check("zd_res_cycles", 32'(last_cyc), 32'd3);
        base_cyc = last_cyc;

        // Delayed responder: A ack +3, B ack +2, Z stb +5.
        da = 3; db = 2; dz = 5;
        n0 = n_res;
        send_cmd(32'h40490FDB, 32'h3F800000);
        wait_res(n0 + 1);
        check("dly_res_z", last_z, 32'h7FC90FDB);
        check("dly_cycles_delta", 32'(last_cyc - base_cyc), 32'd10);

        // Z never arrives: abort at TIMEOUT.
        da = 0; db = 0; dz = 0; z_never = 1'b1;
        n0 = n_res; p0 = n_rst_pulse;
        send_cmd(32'h3F800000, 32'h3F800000);
        wait_res(n0 + 1);
        check("to_res_z", last_z, 32'h7FC00000);
        check("to_res_err", 32'(last_err), 32'd1);
        check("to_res_cycles", 32'(last_cyc), 32'd16);
        check("to_rst_pulses", 32'(n_rst_pulse - p0), 32'd1);
        check("to_z_ack_after", 32'(bus.fadd_z_ack), 32'd0);
        z_never = 1'b0;

        // Z transfer lands exactly on the timeout edge.
        dz = 13;
        n0 = n_res; p0 = n_rst_pulse;
        send_cmd(32'h40000000, 32'h40000000);
        wait_res(n0 + 1);
        check("edge_res_err", 32'(last_err), 32'd0);
        check("edge_res_cycles", 32'(last_cyc), 32'd16);
        check("edge_res_z", last_z, 32'h00000000);
        check("edge_rst_pulses", 32'(n_rst_pulse - p0), 32'd0);
        dz = 0;

        // Reset while waiting for Z.
        z_never = 1'b1;
        send_cmd(32'h11111111, 32'h22222222);
        t = 0;
        while (!bus.fadd_z_ack && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reached_wait_z", 32'(bus.fadd_z_ack), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("midop");
        rst = 1'b0;
        z_never = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ack_after_midop", 32'(bus.cmd_ack), 32'd1);
        n0 = n_res;
        send_cmd(32'h3F800000, 32'h40400000);
        wait_res(n0 + 1);
        check("post_rst_res_z", last_z, 32'h7FC00000);
        check("post_rst_res_err", 32'(last_err), 32'd0);
        check("post_rst_cycles", 32'(last_cyc), 32'd3);

        // Back-to-back commands with a slow host.
        da = 1; db = 0; dz = 2; res_dly = 7;
        n0 = n_res;
        for (int i = 0; i < 4; i++) send_cmd(b2b_a[i], b2b_b[i]);
        wait_res(n0 + 4);
        check("b2b_last_z", last_z, 32'h1D3B5977);
        check("b2b_last_cycles", 32'(last_cyc), 32'd6);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fadd_stream_driver.md
Name: fadd_stream_driver

Overview:
- Initiator for the single-precision float adder's stb/ack operand/result protocol.
- Accepts an operand pair from a host command port and drives the adder's A and B operand handshakes.
- Collects the adder's Z result and returns it with a per-operation latency count and a timeout error flag.
- Used to batch approximate-adder characterisation runs and to measure per-op latency.

Parameters:
TIMEOUT, 16'd1024, max cycles from cmd capture to Z capture before abort (must be >= 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_a  input  32  operand A (IEEE-754 single)
cmd_b  input  32  operand B
cmd_stb  input  1  host offers operand pair
cmd_ack  output  1  driver ready for operand pair
fadd_a  output  32  operand A to adder
fadd_a_stb  output  1  A valid to adder
fadd_a_ack  input  1  adder ready for A
fadd_b  output  32  operand B to adder
fadd_b_stb  output  1  B valid to adder
fadd_b_ack  input  1  adder ready for B
fadd_z  input  32  result from adder
fadd_z_stb  input  1  adder result valid
fadd_z_ack  output  1  driver accepts result
fadd_rst  output  1  one-cycle reset pulse to adder on timeout
res_z  output  32  returned result
res_cycles  output  16  cycles from cmd capture to Z capture, saturating
res_err  output  1  1 = result aborted by timeout
res_stb  output  1  result valid to host
res_ack  input  1  host accepts result

Behaviour:
- Handshake rule, all ports: transfer occurs on a rising edge where stb and ack are both 1.
  - Both sides drop their strobe/ack on the edge following the transfer.
  - Data is held stable while stb = 1.
- Reset values (rst=1 at an edge, any state, mid-op included): state IDLE.
  - cmd_ack, fadd_a_stb, fadd_b_stb, fadd_z_ack, res_stb, res_err, fadd_rst = 0.
  - res_z = 0, res_cycles = 0, cnt = 0.
  - rst has priority over every other assignment.
- States: IDLE, SEND_A, SEND_B, WAIT_Z, PUT_RES.
- IDLE: cmd_ack<=1.
  - On cmd_stb && cmd_ack: latch fadd_a<=cmd_a, fadd_b<=cmd_b; cmd_ack<=0; fadd_a_stb<=1; cnt<=0; go SEND_A.
- SEND_A: on fadd_a_stb && fadd_a_ack: fadd_a_stb<=0, fadd_b_stb<=1, go SEND_B.
- SEND_B: on fadd_b_stb && fadd_b_ack: fadd_b_stb<=0, fadd_z_ack<=1, go WAIT_Z.
- WAIT_Z: on fadd_z_ack && fadd_z_stb: res_z<=fadd_z; res_cycles<=cnt+1 (saturating); res_err<=0; fadd_z_ack<=0; res_stb<=1; go PUT_RES.
- PUT_RES: on res_stb && res_ack: res_stb<=0, go IDLE.
  - cmd_ack rises on the following edge, giving a minimum 1 idle cycle between commands.
- cnt is 16 bit.
  - Increments on every edge in SEND_A/SEND_B/WAIT_Z.
  - Saturates at 16'hFFFF.
  - Frozen in IDLE and PUT_RES.
- Timeout: at an edge in SEND_A/SEND_B/WAIT_Z where cnt+1 == TIMEOUT and no Z transfer occurs on that edge, abort:
  - fadd_a_stb, fadd_b_stb, fadd_z_ack <= 0; fadd_rst<=1 for exactly one cycle.
  - res_z<=32'h7FC00000; res_err<=1; res_cycles<=TIMEOUT; res_stb<=1; go PUT_RES.
- Simultaneous Z transfer and timeout on the same edge: the transfer wins and the result is normal.
- fadd_rst = 0 in all other cycles.
- res_* outputs hold their value until the next capture or abort; they are stable while res_stb = 1.
- cmd_stb is ignored outside IDLE. fadd_*_ack/fadd_z_stb are ignored outside their own states.

Test Plan:
- Bench responder model with programmable ack/stb delays returns Z = A^B.
  - Zero-delay responder, cmd_a=32'h3F800000, cmd_b=32'h40000000 -> fadd_a/fadd_b carry these values.
  - res_z=32'h7F800000, res_err=0, res_cycles = edges counted by bench reference model.
  - res_stb held until res_ack.
- Responder delays A ack 3 cycles, B ack 2, Z stb 5 -> each stb held stable until its ack.
  - res_cycles increases by exactly 10 relative to the zero-delay run.
- TIMEOUT=16, responder never asserts fadd_z_stb.
  - Required: fadd_rst pulses once, 16 cycles after cmd capture.
  - Then res_z=32'h7FC00000, res_err=1, res_cycles=16; fadd_z_ack=0 afterwards.
- Z stb arrives on exactly the timeout edge -> normal result, res_err=0, no fadd_rst pulse.
- rst asserted while in WAIT_Z -> next cycle all outputs at reset values.
  - cmd_ack=1 one cycle later; the following command completes normally.
- 4 back-to-back commands, host holds res_ack low 7 cycles each time.
  - Results return in order with correct values; no second cmd_ack while res_stb=1.
